// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared types, dmem bus codes and size helpers for lsu_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD0  = 3'd1,
        LD1  = 3'd2,
        ST   = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SB   = 2'b11;

    localparam logic [2:0] SL_LW = 3'b000;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] off, input logic [1:0] size);
        case (size)
            SZ_HALF: is_aligned = ~off[0];
            SZ_WORD: is_aligned = (off == 2'b00);
            default: is_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] mw_code(input logic [1:0] size);
        case (size)
            SZ_WORD: mw_code = MW_SW;
            SZ_HALF: mw_code = MW_SH;
            default: mw_code = MW_SB;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// lsu_load_align : selects a byte/half/word from a two-word window and extends it
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] win_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] w_sh;

    assign w_sh = 32'(win_i >> {off_i, 3'b000});

    always_comb begin
        data_o = w_sh;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & w_sh[7]}}, w_sh[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & w_sh[15]}}, w_sh[15:0]};
            default: data_o = w_sh;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : load/store initiator driving dmem, splits misaligned accesses.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests instead of splitting.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int WORD_ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  MemWrite,
    output logic [2:0]  SizeLoad,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [32:0] c_DEPTH_BYTES = 33'd4 << WORD_ADDR_W;

    state_e      state_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  mw_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;

    logic [2:0]  w_nbytes;
    logic [32:0] w_last;
    logic        w_aligned;
    logic        w_reject;
    logic [63:0] w_win;
    logic [31:0] w_ld_data;

`ifndef LSU_MISALIGN_TRAP_EN
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf0_q;
    logic        cross_q;
    logic        split_q;
    logic [1:0]  cnt_q;
    logic        w_cross;
    logic [1:0]  w_cnt_nx;
    logic        w_last_byte;
    logic [7:0]  w_next_byte;
`endif

    assign w_nbytes  = size_bytes(req_size);
    // Last touched byte, one bit wider so addresses near 2^32 cannot wrap into range.
    assign w_last    = {1'b0, req_addr} + {30'd0, w_nbytes} - 33'd1;
    assign w_aligned = is_aligned(req_addr[1:0], req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_reject  = (req_size == SZ_ILL) | (w_last >= c_DEPTH_BYTES) | ~w_aligned;
    assign w_win     = {32'h0, mem_rd};
`else
    assign w_reject    = (req_size == SZ_ILL) | (w_last >= c_DEPTH_BYTES);
    assign w_cross     = ({2'b00, req_addr[1:0]} + {1'b0, w_nbytes}) > 4'd4;
    // The second word is consumed straight off mem_rd on the LD1->RESP edge.
    assign w_win       = (state_q == LD1) ? {mem_rd, buf0_q} : {32'h0, mem_rd};
    assign w_cnt_nx    = cnt_q + 2'd1;
    assign w_last_byte = ({1'b0, cnt_q} == (size_bytes(size_q) - 3'd1));
    assign w_next_byte = 8'(wdata_q >> {w_cnt_nx, 3'b000});
`endif

    lsu_load_align u_align (
        .win_i      (w_win),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (w_ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            off_q        <= 2'b00;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mw_q         <= MW_NONE;
            mem_a_q      <= 32'h0;
            mem_wd_q     <= 32'h0;
`ifndef LSU_MISALIGN_TRAP_EN
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            buf0_q       <= 32'h0;
            cross_q      <= 1'b0;
            split_q      <= 1'b0;
            cnt_q        <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        off_q       <= req_addr[1:0];
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
`ifndef LSU_MISALIGN_TRAP_EN
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cross_q     <= w_cross;
                        split_q     <= ~w_aligned;
                        cnt_q       <= 2'd0;
`endif
                        if (w_reject) begin
                            state_q      <= ERR;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (!req_we) begin
                            state_q <= LD0;
                            mem_a_q <= {req_addr[31:2], 2'b00};
                        end else begin
                            state_q <= ST;
                            mem_a_q <= req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
                            mw_q     <= mw_code(req_size);
                            mem_wd_q <= req_wdata;
`else
                            if (w_aligned) begin
                                mw_q     <= mw_code(req_size);
                                mem_wd_q <= req_wdata;
                            end else begin
                                mw_q     <= MW_SB;
                                mem_wd_q <= {24'h0, req_wdata[7:0]};
                            end
`endif
                        end
                    end
                end
                LD0: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= w_ld_data;
`else
                    buf0_q <= mem_rd;
                    if (cross_q) begin
                        state_q <= LD1;
                        mem_a_q <= mem_a_q + 32'd4;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= w_ld_data;
                    end
`endif
                end
`ifndef LSU_MISALIGN_TRAP_EN
                LD1: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= w_ld_data;
                end
`endif
                ST: begin
`ifdef LSU_MISALIGN_TRAP_EN
                    mw_q         <= MW_NONE;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0;
`else
                    if (split_q && !w_last_byte) begin
                        cnt_q    <= w_cnt_nx;
                        mem_a_q  <= addr_q + {30'd0, w_cnt_nx};
                        mem_wd_q <= {24'h0, w_next_byte};
                    end else begin
                        mw_q         <= MW_NONE;
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end
`endif
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    req_ready_q  <= 1'b1;
                end
                ERR: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    mw_q        <= MW_NONE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign MemWrite   = mw_q;
    assign SizeLoad   = SL_LW;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;

endmodule

`default_nettype wire
